// File: rtl/btle_adv_scheduler.sv
// BLE advertising-event scheduler: walks channels 37/38/39 per channel_map once per adv_interval (option macro: BTLE_ADV_SCHEDULER_RX_WINDOW_EN adds an rx listen window after each tx).
// Latency: tx_start lands in the 3rd cycle counted from the cycle enable is first high in IDLE; load strobes precede tx_start by one cycle.
// Backpressure: waits indefinitely for tx_iq_valid_last from the PHY; dropping enable lets the in-flight packet finish, then returns to IDLE.
module btle_adv_scheduler #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int INTERVAL_BIT_WIDTH       = 24,
    parameter int RX_WINDOW_BIT_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [2:0]                          channel_map,
    input  logic [INTERVAL_BIT_WIDTH-1:0]       adv_interval,
    input  logic [RX_WINDOW_BIT_WIDTH-1:0]      rx_window,
    input  logic                                tx_iq_valid_last,
    input  logic                                rx_decode_end,
    input  logic                                rx_crc_ok,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
    output logic                                tx_channel_number_load,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit,
    output logic                                tx_crc_state_init_bit_load,
    output logic [31:0]                         tx_access_address,
    output logic                                tx_start,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
    output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  rx_unique_bit_sequence,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_state_init_bit,
    output logic                                rx_listen,
    output logic                                rx_event,
    output logic                                rx_event_crc_ok,
    output logic                                busy,
    output logic                                event_done
);

    // Advertising physical-channel access address and CRC preset are fixed by the BLE standard.
    localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;
    localparam logic [23:0] ADV_CRC_INIT    = 24'h555555;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_TX,
`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
        LISTEN,
`endif
        NEXT,
        WAIT_INT
    } state_t;

    state_t                         state;
    logic [2:0]                     map_q;      // channel map frozen at event start
    logic [1:0]                     cur_ch;     // 0/1/2 -> channel 37/38/39
    logic [INTERVAL_BIT_WIDTH-1:0]  int_cnt;
    logic [INTERVAL_BIT_WIDTH-1:0]  int_thresh;
    logic [1:0]                     first_ch;
    logic [1:0]                     next_ch;
    logic                           next_vld;

    function automatic logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] ch_num(input logic [1:0] idx);
        return CHANNEL_NUMBER_BIT_WIDTH'(6'd37 + {4'd0, idx});
    endfunction

    assign tx_crc_state_init_bit  = CRC_STATE_BIT_WIDTH'(ADV_CRC_INIT);
    assign rx_crc_state_init_bit  = CRC_STATE_BIT_WIDTH'(ADV_CRC_INIT);
    assign tx_access_address      = ADV_ACCESS_ADDR;
    assign rx_unique_bit_sequence = LEN_UNIQUE_BIT_SEQUENCE'(ADV_ACCESS_ADDR);

    assign busy = (state != IDLE) && (state != WAIT_INT);

    // An interval of 0 behaves as 1, so the compare threshold bottoms out at 0.
    assign int_thresh = (adv_interval == '0) ? '0 : adv_interval - INTERVAL_BIT_WIDTH'(1);

    // Lowest enabled channel of the live map (used only at event start) and the next one up in the frozen map.
    always_comb begin
        first_ch = 2'd2;
        if (channel_map[0])      first_ch = 2'd0;
        else if (channel_map[1]) first_ch = 2'd1;
        next_vld = 1'b0;
        next_ch  = 2'd0;
        case (cur_ch)
            2'd0: begin
                if (map_q[1]) begin
                    next_vld = 1'b1;
                    next_ch  = 2'd1;
                end else if (map_q[2]) begin
                    next_vld = 1'b1;
                    next_ch  = 2'd2;
                end
            end
            2'd1: begin
                if (map_q[2]) begin
                    next_vld = 1'b1;
                    next_ch  = 2'd2;
                end
            end
            default: ;
        endcase
    end

`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
    logic [RX_WINDOW_BIT_WIDTH-1:0] win_cnt;
`else
    // Listen path compiled out: rx outputs are idle and rx inputs are don't-care.
    logic unused_rx;
    assign unused_rx         = ^{rx_window, rx_decode_end, rx_crc_ok};
    assign rx_listen         = 1'b0;
    assign rx_event          = 1'b0;
    assign rx_event_crc_ok   = 1'b0;
    assign rx_channel_number = ch_num(2'd0);
`endif

    // Event sequencer: state, interval counter and all registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= IDLE;
            map_q                      <= 3'b000;
            cur_ch                     <= 2'd0;
            int_cnt                    <= '0;
            tx_channel_number          <= ch_num(2'd0);
            tx_channel_number_load     <= 1'b0;
            tx_crc_state_init_bit_load <= 1'b0;
            tx_start                   <= 1'b0;
            event_done                 <= 1'b0;
`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
            win_cnt                    <= '0;
            rx_listen                  <= 1'b0;
            rx_event                   <= 1'b0;
            rx_event_crc_ok            <= 1'b0;
            rx_channel_number          <= ch_num(2'd0);
`endif
        end else begin
            tx_channel_number_load     <= 1'b0;
            tx_crc_state_init_bit_load <= 1'b0;
            tx_start                   <= 1'b0;
            event_done                 <= 1'b0;
`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
            rx_event                   <= 1'b0;
`endif
            if (int_cnt != '1) int_cnt <= int_cnt + INTERVAL_BIT_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (enable && channel_map != 3'b000) begin
                        state                      <= LOAD;
                        map_q                      <= channel_map;
                        cur_ch                     <= first_ch;
                        int_cnt                    <= '0;
                        tx_channel_number          <= ch_num(first_ch);
                        tx_channel_number_load     <= 1'b1;
                        tx_crc_state_init_bit_load <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= START;
                    tx_start <= 1'b1;
                end
                START: state <= WAIT_TX;
                WAIT_TX: begin
                    if (tx_iq_valid_last) begin
`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
                        if (rx_window != '0) begin
                            state             <= LISTEN;
                            win_cnt           <= '0;
                            rx_listen         <= 1'b1;
                            rx_channel_number <= tx_channel_number;
                        end else begin
                            state <= NEXT;
                        end
`else
                        state <= NEXT;
`endif
                    end
                end
`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
                LISTEN: begin
                    if (rx_decode_end) begin
                        state           <= NEXT;
                        rx_listen       <= 1'b0;
                        rx_event        <= 1'b1;
                        rx_event_crc_ok <= rx_crc_ok;
                    end else if (rx_window == '0 ||
                                 win_cnt >= rx_window - RX_WINDOW_BIT_WIDTH'(1)) begin
                        state     <= NEXT;
                        rx_listen <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt + RX_WINDOW_BIT_WIDTH'(1);
                    end
                end
`endif
                NEXT: begin
                    // A disable seen here ends the event quietly; the packet already went out.
                    if (!enable) begin
                        state <= IDLE;
                    end else if (next_vld) begin
                        state                      <= LOAD;
                        cur_ch                     <= next_ch;
                        tx_channel_number          <= ch_num(next_ch);
                        tx_channel_number_load     <= 1'b1;
                        tx_crc_state_init_bit_load <= 1'b1;
                    end else begin
                        state      <= WAIT_INT;
                        event_done <= 1'b1;
                    end
                end
                WAIT_INT: begin
                    if (!enable || channel_map == 3'b000) begin
                        state <= IDLE;
                    end else if (int_cnt >= int_thresh) begin
                        state                      <= LOAD;
                        map_q                      <= channel_map;
                        cur_ch                     <= first_ch;
                        int_cnt                    <= '0;
                        tx_channel_number          <= ch_num(first_ch);
                        tx_channel_number_load     <= 1'b1;
                        tx_crc_state_init_bit_load <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btle_adv_scheduler.sv
// Self-checking bench for btle_adv_scheduler: random channel maps, intervals and tx durations vs a timeline model.
// Latency: model places each tx_start from the event start using per-channel air time arithmetic.
// Backpressure: bench plays the PHY, answering each tx_start with tx_iq_valid_last after a chosen delay.
module tb_btle_adv_scheduler;
    localparam int CW = 6, CRW = 24, UW = 32, IW = 24, RW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [2:0]     channel_map = 3'b000;
    logic [IW-1:0]  adv_interval = '0;
    logic [RW-1:0]  rx_window = '0;
    logic           tx_iq_valid_last = 1'b0;
    logic           rx_decode_end = 1'b0;
    logic           rx_crc_ok = 1'b0;
    logic [CW-1:0]  tx_channel_number, rx_channel_number;
    logic           tx_channel_number_load, tx_crc_state_init_bit_load, tx_start;
    logic [CRW-1:0] tx_crc_state_init_bit, rx_crc_state_init_bit;
    logic [31:0]    tx_access_address;
    logic [UW-1:0]  rx_unique_bit_sequence;
    logic           rx_listen, rx_event, rx_event_crc_ok, busy, event_done;

    btle_adv_scheduler #(
        .CHANNEL_NUMBER_BIT_WIDTH(CW), .CRC_STATE_BIT_WIDTH(CRW),
        .LEN_UNIQUE_BIT_SEQUENCE(UW), .INTERVAL_BIT_WIDTH(IW), .RX_WINDOW_BIT_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .channel_map(channel_map),
        .adv_interval(adv_interval), .rx_window(rx_window),
        .tx_iq_valid_last(tx_iq_valid_last), .rx_decode_end(rx_decode_end), .rx_crc_ok(rx_crc_ok),
        .tx_channel_number(tx_channel_number), .tx_channel_number_load(tx_channel_number_load),
        .tx_crc_state_init_bit(tx_crc_state_init_bit),
        .tx_crc_state_init_bit_load(tx_crc_state_init_bit_load),
        .tx_access_address(tx_access_address), .tx_start(tx_start),
        .rx_channel_number(rx_channel_number), .rx_unique_bit_sequence(rx_unique_bit_sequence),
        .rx_crc_state_init_bit(rx_crc_state_init_bit), .rx_listen(rx_listen),
        .rx_event(rx_event), .rx_event_crc_ok(rx_event_crc_ok), .busy(busy), .event_done(event_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observed activity, indexed by cycle number (cycle N = interval after rising edge N).
    int cyc = 0;
    int tx_cyc_q[$];
    int tx_ch_q[$];
    int done_q[$];
    int viol = 0;

    initial begin
        logic p_txs, p_ld, p_crc, p_done, p_rxev;
        p_txs = 0; p_ld = 0; p_crc = 0; p_done = 0; p_rxev = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (tx_start === 1'b1) begin
                tx_cyc_q.push_back(cyc);
                tx_ch_q.push_back(int'(tx_channel_number));
            end
            if (event_done === 1'b1) done_q.push_back(cyc);
            if ((tx_start && p_txs) || (tx_channel_number_load && p_ld) ||
                (tx_crc_state_init_bit_load && p_crc) || (event_done && p_done) ||
                (rx_event && p_rxev)) viol++;
            if (tx_channel_number_load !== tx_crc_state_init_bit_load) viol++;
`ifndef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
            if (rx_listen || rx_event || rx_event_crc_ok) viol++;
`endif
            p_txs = tx_start; p_ld = tx_channel_number_load; p_crc = tx_crc_state_init_bit_load;
            p_done = event_done; p_rxev = rx_event;
        end
    end

    // PHY stand-in: tx_iq_valid_last is high in cycle (tx_start cycle + dur[k]) for the k-th packet.
    int         dur[$];
    int         dur_idx = 0;
    bit         resp_busy = 0;
    bit         map_roll = 0;
    logic [2:0] maps[$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_start === 1'b1) begin
                int d;
                int nx;
                resp_busy = 1;
                d = (dur_idx < dur.size()) ? dur[dur_idx] : 10;
                dur_idx++;
                if (map_roll && maps.size() > 0) begin
                    nx = done_q.size() + 1;
                    if (nx > maps.size() - 1) nx = maps.size() - 1;
                    channel_map = maps[nx];
                end
                repeat (d) @(posedge clk);
                #2 tx_iq_valid_last = 1'b1;
                @(posedge clk);
                #2 tx_iq_valid_last = 1'b0;
                resp_busy = 0;
            end
        end
    end

    task automatic do_reset();
        int w;
        enable = 1'b0;
        map_roll = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        w = 0;
        while (resp_busy && w < 2000) begin
            @(posedge clk);
            #2;
            w++;
        end
        tx_cyc_q.delete(); tx_ch_q.delete(); done_q.delete();
        dur_idx = 0;
    endtask

    // Runs k events with maps[]/dur[] and compares against a timeline built from air-time arithmetic:
    // each channel occupies 3 + d cycles from its load to the next load (or to event_done for the last),
    // and the next event loads at max(event start + interval, event_done + 1).
    task automatic run_sched(input int k, input int iv, input int tmo);
        int e, t, t0, eff, di, w, n;
        int exp_cyc[$];
        int exp_ch[$];
        int exp_done[$];
        adv_interval = IW'(iv);
        channel_map = maps[0];
        map_roll = 1;
        @(posedge clk);
        #2 enable = 1'b1;
        e = cyc;
        w = 0;
        while (done_q.size() < k && w < tmo) begin
            @(posedge clk);
            #2;
            w++;
        end
        enable = 1'b0;
        check("event_count", done_q.size(), k);
        repeat (3) @(posedge clk);
        #2;
        check("idle_after_disable", busy, 0);

        eff = (iv == 0) ? 1 : iv;
        t = e + 1;
        di = 0;
        for (int ev = 0; ev < k; ev++) begin
            t0 = t;
            for (int ch = 0; ch < 3; ch++) begin
                if (maps[ev][ch]) begin
                    exp_cyc.push_back(t + 1);
                    exp_ch.push_back(37 + ch);
                    t = t + 3 + dur[di];
                    di++;
                end
            end
            exp_done.push_back(t);
            t = (t0 + eff > t + 1) ? t0 + eff : t + 1;
        end
        check("tx_count", tx_cyc_q.size(), exp_cyc.size());
        n = (tx_cyc_q.size() < exp_cyc.size()) ? tx_cyc_q.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check("tx_start_cycle", tx_cyc_q[i], exp_cyc[i]);
            check("tx_channel", tx_ch_q[i], exp_ch[i]);
        end
        n = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
        for (int i = 0; i < n; i++) check("event_done_cycle", done_q[i], exp_done[i]);
    endtask

    initial begin
        int w, bcnt;
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_tx_ch", tx_channel_number, 37);
        check("rst_rx_ch", rx_channel_number, 37);
        check("rst_strobes", {tx_start, tx_channel_number_load, tx_crc_state_init_bit_load,
                              event_done, rx_event, rx_listen, rx_event_crc_ok}, 0);
        check("tx_crc_init", tx_crc_state_init_bit, 24'h555555);
        check("rx_crc_init", rx_crc_state_init_bit, 24'h555555);
        check("tx_aa", tx_access_address, 32'h8E89BED6);
        check("rx_aa", rx_unique_bit_sequence, 32'h8E89BED6);
        rst = 1'b0;

        // Three channels, 5000-cycle interval, 100-cycle packets
        do_reset();
        maps = '{3'b111, 3'b111};
        dur.delete();
        for (int i = 0; i < 6; i++) dur.push_back(100);
        run_sched(2, 5000, 12000);
        check("interval_5000", (tx_cyc_q.size() >= 4) ? tx_cyc_q[3] - tx_cyc_q[0] : -1, 5000);

        // Channels 37 and 39 only
        do_reset();
        maps = '{3'b101, 3'b101};
        dur = '{20, 20, 20, 20};
        run_sched(2, 300, 3000);

        // Event longer than interval: next load right after event_done
        do_reset();
        maps = '{3'b001, 3'b001};
        dur = '{300, 300};
        run_sched(2, 100, 3000);
        check("back_to_back", (tx_cyc_q.size() >= 2 && done_q.size() >= 1) ?
              tx_cyc_q[1] - done_q[0] : -1, 2);

        // Empty map keeps the scheduler idle
        do_reset();
        channel_map = 3'b000;
        adv_interval = IW'(50);
        enable = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (busy) bcnt++;
        end
        check("map0_busy_cycles", bcnt, 0);
        check("map0_tx_count", tx_cyc_q.size(), 0);

        // Random maps (changing between events), intervals including 0, and packet lengths
        for (int r = 0; r < 6; r++) begin
            do_reset();
            maps.delete();
            dur.delete();
            for (int i = 0; i < 3; i++) maps.push_back(3'($urandom_range(1, 7)));
            for (int i = 0; i < 9; i++) dur.push_back($urandom_range(1, 60));
            run_sched(3, (r == 0) ? 0 : $urandom_range(1, 400), 6000);
        end

        // Enable dropped while channel 38 is on air
        do_reset();
        dur = '{40, 40, 40};
        channel_map = 3'b111;
        adv_interval = IW'(1000);
        @(posedge clk);
        #2 enable = 1'b1;
        w = 0;
        while (tx_cyc_q.size() < 2 && w < 500) begin
            @(posedge clk);
            #2;
            w++;
        end
        enable = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        check("drop_tx_count", tx_cyc_q.size(), 2);
        check("drop_ch", (tx_ch_q.size() >= 2) ? tx_ch_q[1] : -1, 38);
        check("drop_no_done", done_q.size(), 0);
        check("drop_busy", busy, 0);

        // Reset while waiting for the PHY
        do_reset();
        dur = '{60, 60, 60};
        channel_map = 3'b111;
        @(posedge clk);
        #2 enable = 1'b1;
        w = 0;
        while (tx_cyc_q.size() < 1 && w < 500) begin
            @(posedge clk);
            #2;
            w++;
        end
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #2;
        check("midtx_rst_busy", busy, 0);
        check("midtx_rst_tx_ch", tx_channel_number, 37);
        check("midtx_rst_strobes", {tx_start, tx_channel_number_load, event_done}, 0);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check("midtx_rst_no_tx", tx_cyc_q.size(), 1);

`ifdef BTLE_ADV_SCHEDULER_RX_WINDOW_EN
        begin
            int lcnt;
            // Full listen window with no reception
            do_reset();
            dur = '{20};
            channel_map = 3'b001;
            adv_interval = IW'(3000);
            rx_window = RW'(200);
            @(posedge clk);
            #2 enable = 1'b1;
            lcnt = 0;
            w = 0;
            while (done_q.size() < 1 && w < 3000) begin
                @(posedge clk);
                #2;
                if (rx_listen) lcnt++;
                w++;
            end
            enable = 1'b0;
            check("listen_len", lcnt, 200);
            // Reception in listen cycle 50 ends the window
            do_reset();
            dur = '{20};
            @(posedge clk);
            #2 enable = 1'b1;
            w = 0;
            while (!rx_listen && w < 500) begin
                @(posedge clk);
                #2;
                w++;
            end
            check("listen_open", rx_listen, 1);
            repeat (49) @(posedge clk);
            #2;
            rx_decode_end = 1'b1;
            rx_crc_ok = 1'b1;
            @(posedge clk);
            #2;
            rx_decode_end = 1'b0;
            rx_crc_ok = 1'b0;
            check("rx_event", rx_event, 1);
            check("rx_event_crc_ok", rx_event_crc_ok, 1);
            check("listen_closed", rx_listen, 0);
            @(posedge clk);
            #2;
            check("rx_event_pulse", rx_event, 0);
            check("done_after_rx", done_q.size(), 1);
            enable = 1'b0;
            rx_window = '0;
        end
`endif

        check("strobe_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btle_adv_scheduler.md
BTLE_ADV_SCHEDULER -- requirements
Module: btle_adv_scheduler

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6, width of channel-number ports.
REQ-002 SHALL have parameter CRC_STATE_BIT_WIDTH, default 24, width of CRC init ports.
REQ-003 SHALL have parameter LEN_UNIQUE_BIT_SEQUENCE, default 32, width of rx unique sequence.
REQ-004 SHALL have parameter INTERVAL_BIT_WIDTH, default 24, width of the interval counter and the adv_interval port.
REQ-005 SHALL have parameter RX_WINDOW_BIT_WIDTH, default 16, width of the listen-window counter and the rx_window port.
REQ-006 Ports SHALL be:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
enable  in  1  level; run advertising events.
channel_map  in  3  bit0/1/2 enable channels 37/38/39.
adv_interval  in  INTERVAL_BIT_WIDTH  clk cycles between event starts.
rx_window  in  RX_WINDOW_BIT_WIDTH  listen-window length in cycles.
tx_iq_valid_last  in  1  PHY tx end-of-packet pulse.
rx_decode_end  in  1  PHY rx decode-complete pulse.
rx_crc_ok  in  1  PHY CRC result, valid with rx_decode_end.
tx_channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  current channel.
tx_channel_number_load  out  1  one-cycle load strobe.
tx_crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  constant 24'h555555.
tx_crc_state_init_bit_load  out  1  one-cycle load strobe.
tx_access_address  out  32  constant 32'h8E89BED6.
tx_start  out  1  one-cycle PHY tx start pulse.
rx_channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  channel being listened on.
rx_unique_bit_sequence  out  LEN_UNIQUE_BIT_SEQUENCE  constant 32'h8E89BED6.
rx_crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  constant 24'h555555.
rx_listen  out  1  high while listen window open.
rx_event  out  1  one-cycle pulse on rx_decode_end inside window.
rx_event_crc_ok  out  1  rx_crc_ok captured with rx_event.
busy  out  1  high in any state except IDLE and WAIT_INT.
event_done  out  1  one-cycle pulse when last enabled channel completes.

Function
REQ-007 FSM states SHALL be IDLE, LOAD, START, WAIT_TX, LISTEN, NEXT, WAIT_INT.
REQ-008 IDLE: enable=1 and channel_map!=0 -> LOAD on lowest enabled channel; interval counter cleared to 0; channel_map==0 -> remain IDLE.
REQ-009 LOAD: tx_channel_number_load and tx_crc_state_init_bit_load high exactly 1 cycle, tx_channel_number valid same cycle -> START.
REQ-010 START: tx_start high exactly 1 cycle -> WAIT_TX; latency enable-to-tx_start = 3 cycles from IDLE.
REQ-011 WAIT_TX: hold until tx_iq_valid_last=1 -> LISTEN (macro defined) or NEXT (macro undefined); no timeout.
REQ-012 NEXT: select next higher enabled channel in map order 37,38,39 -> LOAD; none remaining -> pulse event_done, -> WAIT_INT.
REQ-013 channel_map SHALL be sampled once per event, at event start; changes mid-event take effect next event.
REQ-014 Interval counter SHALL increment every cycle from event start, saturate at all-ones, clear at each event start.
REQ-015 WAIT_INT: counter >= adv_interval-1 and enable=1 -> LOAD (new event); enable=0 -> IDLE immediately.
REQ-016 Event longer than adv_interval: WAIT_INT SHALL exit on its first cycle (back-to-back events, no slip accumulation beyond one cycle).
REQ-017 enable deasserted mid-event SHALL NOT abort an in-flight PHY tx; the current WAIT_TX (and LISTEN, if any) completes, then -> IDLE without further channels; event_done is not pulsed.
REQ-018 adv_interval==0 SHALL be treated as 1.
REQ-019 Strobes tx_start, loads, rx_event, event_done SHALL never be high for more than one consecutive cycle.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE and clear all counters, from any state including mid-tx.
REQ-021 Reset values: all strobes, rx_listen, rx_event_crc_ok, busy = 0; tx_channel_number = rx_channel_number = 37; constant outputs hold their constants.

Configuration
REQ-022 Macro BTLE_ADV_SCHEDULER_RX_WINDOW_EN defined: LISTEN state present; rx_listen=1, rx_channel_number=current channel; exit to NEXT on rx_decode_end (pulse rx_event, capture rx_crc_ok) or after rx_window cycles; rx_window==0 skips LISTEN.
REQ-023 Macro undefined: LISTEN absent; rx_listen, rx_event, rx_event_crc_ok tied 0; rx_window and rx_decode_end ignored.

Verification
REQ-024 map=3'b111, interval=5000, macro undefined, tx_iq_valid_last 100 cycles after each tx_start -> tx_start on channels 37,38,39 in order, event_done once, next LOAD exactly 5000 cycles after first.
REQ-025 map=3'b101 -> channels 37 then 39 only; map=3'b000 with enable=1 -> busy stays 0, no tx_start.
REQ-026 Macro defined, rx_window=200, no rx_decode_end -> rx_listen high exactly 200 cycles per channel; with rx_decode_end+rx_crc_ok=1 at cycle 50 -> rx_event=1, rx_event_crc_ok=1, immediate NEXT.
REQ-027 interval=100, tx takes 300 cycles -> new event LOAD 1 cycle after event_done.
REQ-028 enable dropped during WAIT_TX on 38 -> no tx_start after tx_iq_valid_last, IDLE, no event_done; rst asserted in WAIT_TX -> IDLE next cycle, outputs at reset values.
